fp32_seq_divider: RTL and testbench

//  Iterative IEEE-754 single-precision divider, Q = A / B; the inverse operation of the ALU's FP32 multiplier.

---
 rtl/fp32_pkg.sv | 20 ++
 rtl/fp32_div_step.sv | 19 +
 rtl/fp32_seq_divider.sv | 146 ++++++++++++++
 tb/tb_fp32_seq_divider.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the ALU floating-point blocks: field widths,
// exponent bias, special encodings and the divider FSM states.
package fp32_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;

   // Magnitude encodings (sign bit is prepended by the user).
   localparam logic [EXP_W+MAN_W-1:0] INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
   localparam logic [EXP_W+MAN_W-1:0] ZERO_MAG = '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/fp32_div_step.sv
// One restoring-division iteration: subtract the divisor when it fits,
// emit the quotient bit and shift the partial remainder left.
module fp32_div_step (
   input  logic [24:0] rem_i,
   input  logic [23:0] man_b_i,
   output logic [24:0] rem_o,
   output logic        qbit_o
);

   logic [24:0] diff;

   // The remainder stays below 2*man_b, so the shifted result never loses a set bit.
   always_comb begin
      qbit_o = (rem_i >= {1'b0, man_b_i});
      diff   = qbit_o ? (rem_i - {1'b0, man_b_i}) : rem_i;
      rem_o  = diff << 1;
   end

endmodule

// File: rtl/fp32_seq_divider.sv
// Iterative FP32 divider Q = A / B: 25 restoring steps, then normalise/pack.
// Truncating, denormals flushed to zero, one operation in flight at a time.
module fp32_seq_divider #(
   parameter int BIAS = fp32_pkg::BIAS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Output,
   output logic        dz,
   output logic        ovf,
   output logic        unf
);

   import fp32_pkg::*;

   localparam int         QBITS  = 25;
   localparam int         SIG_W  = MAN_W + 1;
   localparam logic [9:0] BIAS_W = 10'(BIAS);

   state_e                 state_q;
   logic                   sign_q;
   logic [EXP_W-1:0]       exp_a_q;
   logic [EXP_W-1:0]       exp_b_q;
   logic [SIG_W-1:0]       man_b_q;
   logic [QBITS-1:0]       rem_q;
   logic [QBITS-1:0]       quo_q;
   logic [4:0]             cnt_q;
   logic [31:0]            out_q;
   logic                   dz_q;
   logic                   ovf_q;
   logic                   unf_q;
   logic                   out_valid_q;
   logic                   in_ready_q;

   logic [QBITS-1:0]       rem_d;
   logic                   qbit_d;
   logic [9:0]             exp_d;
   logic [MAN_W-1:0]       mant_d;
   logic                   sign_d;

   fp32_div_step u_step (
      .rem_i   (rem_q),
      .man_b_i (man_b_q),
      .rem_o   (rem_d),
      .qbit_o  (qbit_d)
   );

   // Quotient lies in (0.5, 2): a clear top bit means one extra normalising shift.
   always_comb begin
      sign_d = A[31] ^ B[31];
      exp_d  = {2'b00, exp_a_q} - {2'b00, exp_b_q} + BIAS_W - {9'd0, ~quo_q[QBITS-1]};
      mant_d = quo_q[QBITS-1] ? quo_q[QBITS-2:1] : quo_q[QBITS-3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sign_q      <= 1'b0;
         exp_a_q     <= '0;
         exp_b_q     <= '0;
         man_b_q     <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  sign_q     <= sign_d;
                  exp_a_q    <= A[30:23];
                  exp_b_q    <= B[30:23];
                  man_b_q    <= {1'b1, B[22:0]};
                  rem_q      <= {2'b01, A[22:0]};
                  quo_q      <= '0;
                  cnt_q      <= '0;
                  dz_q       <= 1'b0;
                  ovf_q      <= 1'b0;
                  unf_q      <= 1'b0;
                  in_ready_q <= 1'b0;
                  if (B[30:23] == '0) begin
                     out_q       <= {sign_d, INF_MAG};
                     dz_q        <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else if (A[30:23] == '0) begin
                     out_q       <= {sign_d, ZERO_MAG};
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     state_q <= S_DIV;
                  end
               end
            end
            S_DIV: begin
               rem_q <= rem_d;
               quo_q <= {quo_q[QBITS-2:0], qbit_d};
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'(QBITS - 1)) begin
                  state_q <= S_NORM;
               end
            end
            S_NORM: begin
               if ($signed(exp_d) >= 10'sd255) begin
                  out_q <= {sign_q, INF_MAG};
                  ovf_q <= 1'b1;
               end else if ($signed(exp_d) <= 10'sd0) begin
                  out_q <= {sign_q, ZERO_MAG};
                  unf_q <= 1'b1;
               end else begin
                  out_q <= {sign_q, exp_d[EXP_W-1:0], mant_d};
               end
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Output    = out_q;
   assign dz        = dz_q;
   assign ovf       = ovf_q;
   assign unf       = unf_q;

endmodule

// File: tb/tb_fp32_seq_divider.sv
// Bench for fp32_seq_divider: directed vectors, special cases, back-pressure,
// mid-operation reset and random operands against an integer reference model.
module tb_fp32_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Output;
   logic        dz;
   logic        ovf;
   logic        unf;

   int n_cmp = 0;
   int n_err = 0;

   // Scoreboard entries are {Output, dz, ovf, unf}.
   logic [34:0] exp_q[$];
   int          lat_q[$];

   fp32_seq_divider dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Output    (Output),
      .dz        (dz),
      .ovf       (ovf),
      .unf       (unf)
   );

   always #5 clk = ~clk;

   // Reference: integer long division of the significands, then truncation.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      int          ea;
      int          eb;
      int          e;
      longint      ma;
      longint      mb;
      longint      q;
      logic [22:0] mant;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (eb == 0) return {s, 8'hFF, 23'h0, 3'b100};
      if (ea == 0) return {s, 31'h0, 3'b000};
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      q  = (ma <<< 24) / mb;
      if (q >= 64'sd16777216) begin
         mant = 23'(q >>> 1);
         e    = ea - eb + 127;
      end else begin
         mant = 23'(q);
         e    = ea - eb + 126;
      end
      if (e >= 255) return {s, 8'hFF, 23'h0, 3'b010};
      if (e <= 0)   return {s, 31'h0, 3'b001};
      return {s, 8'(e), mant, 3'b000};
   endfunction

   function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? 1 : 27;
   endfunction

   task automatic abort(input string what);
      n_cmp++;
      n_err++;
      $display("FAIL %s: DUT did not respond within the cycle bound", what);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   endtask

   // Drive one operand pair; returns 1 ns after the accepting edge.
   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [34:0] exp, input int lat, input bit push);
      int w;
      w = 0;
      @(negedge clk);
      A        = a;
      B        = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1) begin
         @(negedge clk);
         w++;
         if (w > 100) abort("accept_wait");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A        = $urandom;
      B        = $urandom;
      if (push) begin
         exp_q.push_back(exp);
         lat_q.push_back(lat);
      end
   endtask

   // Wait for out_valid, counting edges with the accepting edge as 1.
   task automatic receive(output logic [34:0] got, output int lat);
      lat = 1;
      while (out_valid !== 1'b1) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat > 100) abort("result_wait");
      end
      got = {Output, dz, ovf, unf};
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if (Output !== 32'h0) begin
         n_err++;
         $display("FAIL reset_output: got %h want 00000000", Output);
      end
      n_cmp++;
      if ({dz, ovf, unf} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 000", {dz, ovf, unf});
      end
   endtask

   task automatic test_directed();
      logic [31:0] ta[7];
      logic [31:0] tb[7];
      logic [34:0] te[7];
      int          tl[7];
      logic [34:0] got;
      logic [34:0] exp;
      int          lat;
      int          el;
      ta[0] = 32'h40C00000; tb[0] = 32'h40000000; te[0] = {32'h40400000, 3'b000}; tl[0] = 27;
      ta[1] = 32'h3F800000; tb[1] = 32'h40400000; te[1] = {32'h3EAAAAAA, 3'b000}; tl[1] = 27;
      ta[2] = 32'hC1000000; tb[2] = 32'h3F000000; te[2] = {32'hC1800000, 3'b000}; tl[2] = 27;
      ta[3] = 32'h3F800000; tb[3] = 32'h00000000; te[3] = {32'h7F800000, 3'b100}; tl[3] = 1;
      ta[4] = 32'h00000000; tb[4] = 32'h40A00000; te[4] = {32'h00000000, 3'b000}; tl[4] = 1;
      ta[5] = 32'h7F000000; tb[5] = 32'h00800000; te[5] = {32'h7F800000, 3'b010}; tl[5] = 27;
      ta[6] = 32'h00800000; tb[6] = 32'h7F000000; te[6] = {32'h00000000, 3'b001}; tl[6] = 27;
      for (int i = 0; i < 7; i++) begin
         send(ta[i], tb[i], te[i], tl[i], 1'b1);
         receive(got, lat);
         exp = exp_q.pop_front();
         el  = lat_q.pop_front();
         n_cmp++;
         if (got[34:3] !== exp[34:3]) begin
            n_err++;
            $display("FAIL directed_%0d_output: got %h want %h", i, got[34:3], exp[34:3]);
         end
         n_cmp++;
         if (got[2:0] !== exp[2:0]) begin
            n_err++;
            $display("FAIL directed_%0d_flags(dz,ovf,unf): got %b want %b", i, got[2:0], exp[2:0]);
         end
         n_cmp++;
         if (lat !== el) begin
            n_err++;
            $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, el);
         end
         drain();
      end
   endtask

   task automatic test_backpressure();
      logic [34:0] got;
      logic [34:0] exp;
      int          lat;
      send(32'h40C00000, 32'h40000000, {32'h40400000, 3'b000}, 27, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      A        = 32'h3F800000;
      B        = 32'h40400000;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      receive(got, lat);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if ({Output, dz, ovf, unf} !== exp_q[0]) begin
            n_err++;
            $display("FAIL hold_%0d_result: got %h want %h", c, {Output, dz, ovf, unf}, exp_q[0]);
         end
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_%0d_handshake: got in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid);
         end
      end
      exp = exp_q.pop_front();
      void'(lat_q.pop_front());
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL hold_first_result: got %h want %h", got, exp);
      end
      drain();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL after_drain: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ignored_operand: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [34:0] got;
      logic [34:0] exp;
      int          lat;
      int          el;
      send(32'h40C00000, 32'h40000000, '0, 0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      send(32'h40C00000, 32'h40000000, {32'h40400000, 3'b000}, 27, 1'b1);
      receive(got, lat);
      exp = exp_q.pop_front();
      el  = lat_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL post_reset_result: got %h want %h", got, exp);
      end
      n_cmp++;
      if (lat !== el) begin
         n_err++;
         $display("FAIL post_reset_latency: got %0d want %0d", lat, el);
      end
      drain();
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      logic [34:0] got;
      logic [34:0] exp;
      int          lat;
      int          el;
      for (int i = 0; i < 24; i++) begin
         a = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 23'($urandom)};
         b = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 23'($urandom)};
         send(a, b, model(a, b), model_lat(a, b), 1'b1);
         receive(got, lat);
         exp = exp_q.pop_front();
         el  = lat_q.pop_front();
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL random_%0d %h/%h: got %h want %h", i, a, b, got, exp);
         end
         n_cmp++;
         if (lat !== el) begin
            n_err++;
            $display("FAIL random_%0d_latency: got %0d want %0d", i, lat, el);
         end
         drain();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
